// File: rtl/an_n13_pkg.sv
// Shared constants for the AN-13 code path: Barrett reducer and AN decoder
// agree on the modulus, the Barrett constant and the quotient/residue widths.
package an_n13_pkg;

    localparam int A    = 13;
    localparam int CW_W = 7;
    localparam int K    = 8;
    localparam int MU   = 19;

    localparam int Q_W  = 3;
    localparam int R_W  = 4;

    // Internal widths: the exact product, the estimated quotient (up to 9)
    // and the uncorrected residue (up to 2*A-1).
    localparam int P_W  = 12;
    localparam int QE_W = 4;
    localparam int RE_W = 5;

    typedef logic [Q_W-1:0] quotient_t;
    typedef logic [R_W-1:0] residue_t;

endpackage

// File: rtl/barrett_reducer_n13.sv
// Three-stage Barrett reduction of an AN codeword into quotient and residue
// modulo A, with a single global stall driven by the downstream ready.
module barrett_reducer_n13 #(
    parameter int A    = an_n13_pkg::A,
    parameter int CW_W = an_n13_pkg::CW_W,
    parameter int K    = an_n13_pkg::K,
    parameter int MU   = an_n13_pkg::MU
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [CW_W-1:0]             in_cw,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [an_n13_pkg::Q_W-1:0]  quotient,
    output logic [an_n13_pkg::R_W-1:0]  residue,
    output logic                        q_ovf,
    input  logic                        out_ready
);

    import an_n13_pkg::*;

    localparam logic [P_W-1:0]  MU_V = P_W'(MU);
    localparam logic [CW_W-1:0] A_CW = CW_W'(A);
    localparam logic [RE_W-1:0] A_RE = RE_W'(A);
    localparam logic [QE_W-1:0] Q_MAX = QE_W'((1 << Q_W) - 1);

    logic            adv;
    logic            v1, v2, v3;

    logic [CW_W-1:0] cw1;
    logic [P_W-1:0]  p1;
    logic [P_W-1:0]  prod;

    logic [QE_W-1:0] q2;
    logic [RE_W-1:0] r2;
    logic [QE_W-1:0] q_est;
    logic [RE_W-1:0] r_est;

    quotient_t       q3;
    residue_t        r3;
    logic            ovf3;
    logic [QE_W-1:0] q_cor;
    residue_t        r_cor;

    // The whole pipe moves together; a full output slot that is not taken
    // freezes every stage, so the input side must stall as well.
    assign adv       = !v3 || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;
    assign quotient  = q3;
    assign residue   = r3;
    assign q_ovf     = ovf3;

    // Constant multiply by MU as a sum of shifted copies of the codeword.
    always_comb begin
        prod = '0;
        for (int i = 0; i < P_W; i++) begin
            if (MU_V[i]) begin
                prod = prod + (P_W'(in_cw) << i);
            end
        end
    end

    // MU*A < 2^K, so the estimate never overshoots and the residue stays non-negative.
    always_comb begin
        q_est = QE_W'(p1 >> K);
        r_est = RE_W'(cw1 - CW_W'(q_est) * A_CW);
    end

    // The estimate is short by at most one, so one conditional subtract suffices.
    always_comb begin
        if (r2 >= A_RE) begin
            r_cor = R_W'(r2 - A_RE);
            q_cor = q2 + QE_W'(1);
        end else begin
            r_cor = R_W'(r2);
            q_cor = q2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            cw1  <= '0;
            p1   <= '0;
            q2   <= '0;
            r2   <= '0;
            q3   <= '0;
            r3   <= '0;
            ovf3 <= 1'b0;
        end else if (adv) begin
            v1   <= in_valid;
            cw1  <= in_cw;
            p1   <= prod;
            v2   <= v1;
            q2   <= q_est;
            r2   <= r_est;
            v3   <= v2;
            q3   <= q_cor[Q_W-1:0];
            r3   <= r_cor;
            ovf3 <= (q_cor > Q_MAX);
        end
    end

    a_residue_in_range: assert property (
        @(posedge clk) disable iff (rst) v3 |-> (RE_W'(r3) < A_RE)
    );

endmodule

// File: tb/tb_barrett_reducer_n13.sv
// Directed bench for barrett_reducer_n13: a queue of reference results is
// filled on accepted inputs and drained against every consumed output.
module tb_barrett_reducer_n13;

    typedef struct packed {
        logic [2:0] q;
        logic [3:0] r;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [6:0] in_cw;
    logic       in_ready;
    logic       out_valid;
    logic [2:0] quotient;
    logic [3:0] residue;
    logic       q_ovf;
    logic       out_ready;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    barrett_reducer_n13 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_cw     (in_cw),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .quotient  (quotient),
        .residue   (residue),
        .q_ovf     (q_ovf),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic exp_t ref_model(input int x);
        exp_t e;
        int   qt;
        qt    = x / 13;
        e.q   = qt[2:0];
        e.r   = 4'(x % 13);
        e.ovf = (qt > 7);
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("[TB] FAIL unexpected_output observed=q%0d/r%0d expected=no_output", quotient, residue);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("quotient", quotient, e.q);
            check_eq("residue", residue, e.r);
            check_eq("q_ovf", q_ovf, e.ovf);
        end
    endtask

    // One clock cycle: drive at the falling edge, observe, then cross the rising edge.
    task automatic apply_stimulus(input logic v, input int cw, input logic ordy);
        in_valid  = v;
        in_cw     = 7'(cw);
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) check_output();
        if (in_valid && in_ready) sb.push_back(ref_model(cw));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            apply_stimulus(1'b0, 0, 1'b1);
        end
        check_eq("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_cw     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_quotient", quotient, 0);
        check_eq("reset_residue", residue, 0);
        check_eq("reset_q_ovf", q_ovf, 0);
        rst = 1'b0;
        #1;
        check_eq("ready_after_reset", in_ready, 1);
        @(negedge clk);

        // Single codeword 91 with latency check
        apply_stimulus(1'b1, 91, 1'b1);
        check_eq("lat91_edge1", out_valid, 0);
        apply_stimulus(1'b0, 0, 1'b1);
        check_eq("lat91_edge2", out_valid, 0);
        apply_stimulus(1'b0, 0, 1'b1);
        check_eq("lat91_edge3", out_valid, 1);
        drain(4);

        // Back-to-back 0, 90, 127 then 123
        apply_stimulus(1'b1, 0, 1'b1);
        apply_stimulus(1'b1, 90, 1'b1);
        apply_stimulus(1'b1, 127, 1'b1);
        check_eq("b2b_first_valid", out_valid, 1);
        apply_stimulus(1'b1, 123, 1'b1);
        check_eq("b2b_second_valid", out_valid, 1);
        apply_stimulus(1'b0, 0, 1'b1);
        check_eq("b2b_third_valid", out_valid, 1);
        drain(5);

        // Sweep every codeword with sporadic bubbles
        for (int x = 0; x < 128; x++) begin
            if ($urandom_range(0, 3) == 0) apply_stimulus(1'b0, 0, 1'b1);
            apply_stimulus(1'b1, x, 1'b1);
        end
        drain(6);

        // Stall four cycles once 13 reaches the output
        apply_stimulus(1'b1, 13, 1'b1);
        apply_stimulus(1'b1, 26, 1'b1);
        apply_stimulus(1'b1, 39, 1'b1);
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b0;
            out_ready = 1'b0;
            #1;
            check_eq("stall_in_ready", in_ready, 0);
            check_eq("stall_out_valid", out_valid, 1);
            check_eq("stall_quotient", quotient, 1);
            check_eq("stall_residue", residue, 0);
            apply_stimulus(1'b0, 0, 1'b0);
        end
        drain(6);

        // Reset with three codewords in flight
        apply_stimulus(1'b1, 10, 1'b1);
        apply_stimulus(1'b1, 20, 1'b1);
        apply_stimulus(1'b1, 30, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("midreset_out_valid", out_valid, 0);
        check_eq("midreset_quotient", quotient, 0);
        sb.delete();
        @(negedge clk);
        apply_stimulus(1'b0, 0, 1'b1);
        rst = 1'b0;
        apply_stimulus(1'b1, 52, 1'b1);
        drain(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
